// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  // Expands a 4-bit byte-enable into a 32-bit bit-enable.
  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a synchronous byte-masked write and a combinational read.
// Contents are deliberately not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wmask_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] bitMask;

  assign bitMask = byte_mask(wmask_i);

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & ~bitMask) | (wdata_i & bitMask);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one outstanding request, fixed access latency, byte-masked stores,
// range/alignment checking and a registered response held until the consumer takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             accWrite;
  logic [31:0]      accAddr;
  logic [31:0]      accWdata;
  logic [3:0]       accWmask;
  logic             accErr;
  logic             doAccess;
  logic             arrWe;
  logic [31:0]      arrRdata;

  // With LATENCY=1 the access happens on the accept edge, so it uses the live request.
  always_comb begin
    if (state_q == IDLE) begin
      accWrite = req_write;
      accAddr  = req_addr;
      accWdata = req_wdata;
      accWmask = req_wmask;
    end else begin
      accWrite = write_q;
      accAddr  = addr_q;
      accWdata = wdata_q;
      accWmask = wmask_q;
    end
  end

  assign accErr = (accAddr[1:0] != 2'b00) || (accAddr[31:2] >= 30'(DEPTH_WORDS));
  assign arrWe  = doAccess && accWrite && !accErr;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we_i   (arrWe),
    .addr_i (accAddr[AW+1:2]),
    .wdata_i(accWdata),
    .wmask_i(accWmask),
    .rdata_o(arrRdata)
  );

  // rsp_valid rises one edge after entering RESP, so it appears LATENCY edges after accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    doAccess = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          if (LATENCY == 1) begin
            doAccess = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          doAccess = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
        end else if (rsp_ready) begin
          rvalid_d = 1'b0;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (doAccess) begin
      err_d   = accErr;
      rdata_d = (!accWrite && !accErr) ? arrRdata : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wmask_q  <= 4'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/stall sequences, randomized
// traffic against a byte-level memory model, and a LATENCY=1 back-to-back run.
module tb_dmem_responder;

  localparam int DEPTH_A = 64;
  localparam int LAT_A   = 2;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wmask;

  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wmask;

  dmem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(1)) dutB (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  int nCompared = 0;
  int nMismatch = 0;
  logic [31:0] model [DEPTH_A];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Counts edges until rsp_valid is seen, sampling 1 time unit after each edge.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Entered just after a negedge with the DUT idle; returns after the next negedge.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input int stall,
                               output logic [31:0] rd, output logic e, output int lat);
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_wmask = m;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitRsp(lat);
    rd = rsp_rdata;
    e  = rsp_err;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl [14];
    vec_t        bt [7];
    logic [31:0] rd;
    logic        e;
    int          lat;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1};
    tbl[5]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h102, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[9]  = '{1'b1, 32'h20,  32'h11111111, 4'hF, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 32'h24,  32'h55667788, 4'hF, 32'h0,        1'b0};
    tbl[11] = '{1'b1, 32'h24,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h24,  32'h0,        4'h0, 32'h55667788, 1'b0};
    tbl[13] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11111111, 1'b0};

    bt[0] = '{1'b1, 32'h0,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
    bt[1] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
    bt[2] = '{1'b1, 32'h4,  32'h12345678, 4'hF, 32'h0,        1'b0};
    bt[3] = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h12345678, 1'b0};
    bt[4] = '{1'b0, 32'h6,  32'h0,        4'h0, 32'h0,        1'b1};
    bt[5] = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
    bt[6] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

    rst = 1'b1;
    {req_valid, req_write, rsp_ready} = 3'b000;
    {req_addr, req_wdata, req_wmask} = '0;
    {b_req_valid, b_req_write, b_rsp_ready} = 3'b000;
    {b_req_addr, b_req_wdata, b_req_wmask} = '0;
    repeat (2) @(negedge clk);

    checkOutput("reset req_ready", 32'(req_ready), 32'h1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset rsp_err",   32'(rsp_err),   32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, 0, rd, e, lat);
      checkOutput($sformatf("vec%0d rdata", i),   rd,         tbl[i].expRdata);
      checkOutput($sformatf("vec%0d err", i),     32'(e),     32'(tbl[i].expErr));
      checkOutput($sformatf("vec%0d latency", i), 32'(lat),   32'(LAT_A));
    end

    // Reset while a store to 0x20 is still pending must lose that store.
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h22222222;
    req_wmask = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    checkOutput("busy req_ready", 32'(req_ready), 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("async rst req_ready", 32'(req_ready), 32'h1);
    checkOutput("async rst rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("async rst rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("async rst rsp_err",   32'(rsp_err),   32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
    checkOutput("post-reset load 0x20", rd, 32'h11111111);

    // Back-pressure: response held stable and new requests refused until drained.
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    waitRsp(lat);
    checkOutput("stall first latency", 32'(lat), 32'(LAT_A));
    req_addr  = 32'h20;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d req_ready", k), 32'(req_ready), 32'h0);
      checkOutput($sformatf("stall%0d rsp_valid", k), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("stall%0d rsp_rdata", k), rsp_rdata, 32'hDEADBEAA);
      checkOutput($sformatf("stall%0d rsp_err", k),   32'(rsp_err), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("drain rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("drain req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("late accept req_ready", 32'(req_ready), 32'h0);
    waitRsp(lat);
    checkOutput("late accept latency", 32'(lat), 32'(LAT_A));
    checkOutput("late accept rdata", rsp_rdata, 32'h11111111);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);

    // Randomized traffic against a byte-level model; every word is written first.
    for (int w = 0; w < DEPTH_A; w++) begin
      model[w] = $urandom;
      applyStimulus(1'b1, 32'(w) * 4, model[w], 4'hF, 0, rd, e, lat);
      checkOutput($sformatf("init%0d err", w), 32'(e), 32'h0);
    end
    for (int n = 0; n < 200; n++) begin
      logic        wr, expErr;
      logic [31:0] a, wd, expRd;
      logic [3:0]  m;
      int          sel, idx;
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH_A - 1)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH_A - 1)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'($urandom_range(DEPTH_A, 1000)) * 4;
      else               a = ($urandom | 32'h80000000) & 32'hFFFFFFFC;
      wd  = $urandom;
      m   = 4'($urandom_range(0, 15));
      expErr = (a % 4 != 0) || (a / 4 >= DEPTH_A);
      idx = expErr ? 0 : int'(a / 4);
      if (wr && !expErr) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
      expRd = (!wr && !expErr) ? model[idx] : 32'h0;
      applyStimulus(wr, a, wd, m, $urandom_range(0, 2), rd, e, lat);
      checkOutput($sformatf("rand%0d rdata a=%h", n, a), rd, expRd);
      checkOutput($sformatf("rand%0d err a=%h", n, a), 32'(e), 32'(expErr));
      checkOutput($sformatf("rand%0d latency", n), 32'(lat), 32'(LAT_A));
    end

    // LATENCY=1 instance with requests offered continuously and rsp_ready held high.
    begin
      int nAcc    = 0;
      int nRsp    = 0;
      int lastAcc = -100;
      b_rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 100 && nRsp < 7; cyc++) begin
        @(negedge clk);
        if (b_rsp_valid) begin
          checkOutput($sformatf("b%0d rdata", nRsp), b_rsp_rdata, bt[nRsp].expRdata);
          checkOutput($sformatf("b%0d err", nRsp), 32'(b_rsp_err), 32'(bt[nRsp].expErr));
          checkOutput($sformatf("b%0d rsp delay", nRsp), 32'(cyc - lastAcc), 32'd2);
          nRsp++;
        end
        if (b_req_ready && nAcc < 7) begin
          b_req_write = bt[nAcc].write;
          b_req_addr  = bt[nAcc].addr;
          b_req_wdata = bt[nAcc].wdata;
          b_req_wmask = bt[nAcc].wmask;
          b_req_valid = 1'b1;
          if (nAcc > 0) checkOutput($sformatf("b%0d accept spacing", nAcc), 32'(cyc - lastAcc), 32'd3);
          lastAcc = cyc;
          nAcc++;
        end else if (b_req_ready) begin
          b_req_valid = 1'b0;
        end
      end
      b_req_valid = 1'b0;
      checkOutput("b response count", 32'(nRsp), 32'd7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
